burst_write_buffer: RTL and testbench
=====================================

# burst_write_buffer

Collects single-word writes from the burst-read DMA output port into a line buffer and writes them to DDR as one fixed-length burst. It sits directly downstream of the DMA that copies bursts into a frame/sprite buffer. It converts the word-oriented asynchronous write port (wr/addr/din/wait_n) into the burst write port of the DDR arbiter (wr/addr/din/burstLength/wait_n/burstDone).

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width on both ports
- DATA_WIDTH, 64, word width; fixes the word size at 8 bytes
- BURST_LENGTH, 16, words per burst; power of two, 2..128

Ports:
- clock  input  1  single clock
- reset  input  1  asynchronous, active-low reset
- in_wr  input  1  word write request
- in_addr  input  ADDR_WIDTH  byte address of the word
- in_din  input  DATA_WIDTH  write data
- in_wait_n  output  1  high = input port can accept a word
- out_wr  output  1  burst write request / data valid
- out_addr  output  ADDR_WIDTH  burst base byte address, aligned to BURST_LENGTH*8
- out_din  output  DATA_WIDTH  current burst word
- out_burstLength  output  8  constant BURST_LENGTH
- out_wait_n  input  1  high = DDR accepts the current word
- out_burstDone  input  1  one-cycle pulse when the DDR completes the burst

## Operation
- Words and bursts:
  - Accepted input word: in_wr & in_wait_n.
  - Accepted output word: out_wr & out_wait_n.
- Word index = in_addr[log2(BURST_LENGTH)+2 : 3]. Line base = in_addr with the low log2(BURST_LENGTH)+3 bits cleared.
- FSM states: FILL, BURST, DONE_WAIT. Reset state is FILL.
- FILL:
  - in_wait_n = 1.
  - Each accepted word is written to buffer[word index].
  - fillCount increments on each accepted word.
  - The line base is latched on the accepted word when fillCount = 0.
  - When the accepted word brings fillCount to BURST_LENGTH:
    - go to BURST;
    - clear fillCount and burstIdx.
- BURST:
  - in_wait_n = 0.
  - out_wr = 1, out_addr = latched line base, out_din = buffer[burstIdx].
  - Each accepted output word increments burstIdx.
  - On acceptance of word BURST_LENGTH-1:
    - out_burstDone in the same cycle -> FILL;
    - otherwise -> DONE_WAIT.
- DONE_WAIT:
  - out_wr = 0, in_wait_n = 0.
  - out_burstDone -> FILL.
- Boundary rules:
  - out_burstDone seen in FILL or in BURST before the last word is ignored.
  - Duplicate word indices within one line overwrite the buffer entry and still count toward fillCount. The producer guarantees sequential, aligned addresses.
  - No partial-burst flush. A line with fewer than BURST_LENGTH words stays buffered.
  - Counter widths are log2(BURST_LENGTH)+1 bits. Neither counter wraps in normal operation.
  - Reset asserted mid-burst:
    - immediately returns to FILL;
    - clears counters and drops out_wr;
    - buffer contents are don't-care.

## Timing
- Output reset values:
  - in_wait_n = 1, out_wr = 0, out_addr = 0;
  - out_din = buffer[0] (don't-care);
  - out_burstLength = BURST_LENGTH.
- in_wait_n and out_wr are decoded from the registered state. No combinational path from in_wr, out_wait_n or out_burstDone to any output.
- Fill to write handoff: in_wait_n falls and out_wr rises in the cycle after the BURST_LENGTH-th accepted input word.
- Word throughput: one word per cycle on each port while its wait_n is held high.
- Minimum line turnaround is BURST_LENGTH (fill) + BURST_LENGTH (burst) cycles.
- in_wait_n returns high the cycle after the last output word when burstDone coincides with it. Otherwise it returns the cycle after burstDone.
- out_din changes only on accepted output words. It holds while out_wait_n = 0.

## Structure
- Shared package (with the other DDR-side blocks): the BURST_LENGTH default, the state enum {FILL, BURST, DONE_WAIT} and the burst address alignment helper.
- One sub-module: burst_line_buffer.
  - BURST_LENGTH x DATA_WIDTH register array.
  - One write port (index, data, enable) and one asynchronous read port (index).
- FSM, counters and the address latch live in the top.

## Test plan
- Reset, then 16 words at addr 0x100..0x178 with data 0..15, out_wait_n = 1, burstDone pulsed after word 15:
  - out_wr rises one cycle after word 15 is accepted;
  - out_addr = 0x100 throughout;
  - out_din sequence is 0..15;
  - in_wait_n is high again after burstDone.
- Same stream with out_wait_n toggling 1/0 every cycle:
  - out_din holds on wait cycles;
  - all 16 words are delivered in order;
  - the burst takes 32 cycles.
- burstDone coincident with the last word vs burstDone 5 cycles late:
  - coincident case: FILL is resumed next cycle;
  - late case: DONE_WAIT is held 5 cycles with out_wr = 0 and in_wait_n = 0.
- in_wr held high during BURST:
  - no word is accepted;
  - buffer contents are unchanged;
  - the next line begins at fillCount 0 after return to FILL.
- Reset pulsed low at burst word 7:
  - out_wr = 0 and in_wait_n = 1 in the same cycle as the reset assertion;
  - a fresh 16-word line at 0x200 then produces a correct burst at 0x200.
- Spurious burstDone in FILL after 3 words: no state change; the line completes normally after 13 more words.

Source files
------------

// File: rtl/burst_write_buffer_pkg.sv
// Shared DDR-side definitions: default burst length, burst FSM states and
// the helper that aligns a byte address down to a burst boundary.
package burst_write_buffer_pkg;

    localparam int BWB_BURST_LENGTH   = 16;
    localparam int BWB_WORD_BYTES_LG2 = 3;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        BURST     = 2'd1,
        DONE_WAIT = 2'd2
    } bwb_state_e;

    // Clear the address bits that lie inside one burst of burst_len 8-byte words.
    function automatic logic [63:0] burst_align(input logic [63:0] addr,
                                                input int unsigned burst_len);
        logic [63:0] mask;
        mask = (64'(burst_len) << BWB_WORD_BYTES_LG2) - 64'd1;
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/burst_write_buffer_line.sv
// Line storage for one burst: indexed write port, combinational read port.
module burst_line_buffer #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
    input  logic [DATA_WIDTH-1:0]    wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
    output logic [DATA_WIDTH-1:0]    rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Store one word per accepted input write; no reset, contents are scratch.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/burst_write_buffer.sv
// Gathers single-word writes into a line, then replays the line to the DDR
// arbiter as one fixed-length burst and waits for its completion pulse.
module burst_write_buffer
    import burst_write_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int BURST_LENGTH = BWB_BURST_LENGTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_wr_i,
    input  logic [ADDR_WIDTH-1:0] in_addr_i,
    input  logic [DATA_WIDTH-1:0] in_din_i,
    output logic                  in_wait_n_o,
    output logic                  out_wr_o,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic [DATA_WIDTH-1:0] out_din_o,
    output logic [7:0]            out_burst_length_o,
    input  logic                  out_wait_n_i,
    input  logic                  out_burst_done_i
);

    localparam int IDX_W = $clog2(BURST_LENGTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LENGTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    bwb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      fill_cnt_q, fill_cnt_d;
    logic [CNT_W-1:0]      burst_idx_q, burst_idx_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] line_base;
    logic                  in_acc;
    logic                  out_acc;

    // Handshake outputs depend only on the registered state.
    assign in_wait_n_o        = (state_q == FILL);
    assign out_wr_o           = (state_q == BURST);
    assign out_addr_o         = base_q;
    assign out_burst_length_o = 8'(BURST_LENGTH);

    assign in_acc    = in_wr_i & in_wait_n_o;
    assign out_acc   = out_wr_o & out_wait_n_i;
    assign line_base = ADDR_WIDTH'(burst_align(64'(in_addr_i), BURST_LENGTH));

    burst_line_buffer #(
        .DEPTH      (BURST_LENGTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_line (
        .clk_i     (clk_i),
        .wr_en_i   (in_acc),
        .wr_idx_i  (in_addr_i[IDX_W+2:3]),
        .wr_data_i (in_din_i),
        .rd_idx_i  (burst_idx_q[IDX_W-1:0]),
        .rd_data_o (out_din_o)
    );

    // Next-state decode: fill counting, burst word stepping, completion wait.
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        burst_idx_d = burst_idx_q;
        base_d      = base_q;
        unique case (state_q)
            FILL: begin
                if (in_acc) begin
                    if (fill_cnt_q == '0) begin
                        base_d = line_base;
                    end
                    if (fill_cnt_q == CNT_LAST) begin
                        fill_cnt_d  = '0;
                        burst_idx_d = '0;
                        state_d     = BURST;
                    end else begin
                        fill_cnt_d = fill_cnt_q + CNT_ONE;
                    end
                end
            end
            BURST: begin
                if (out_acc) begin
                    burst_idx_d = burst_idx_q + CNT_ONE;
                    if (burst_idx_q == CNT_LAST) begin
                        state_d = out_burst_done_i ? FILL : DONE_WAIT;
                    end
                end
            end
            DONE_WAIT: begin
                if (out_burst_done_i) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State, counters and latched line base; reset drops the burst at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= FILL;
            fill_cnt_q  <= '0;
            burst_idx_q <= '0;
            base_q      <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            burst_idx_q <= burst_idx_d;
            base_q      <= base_d;
        end
    end

endmodule

// File: tb/tb_burst_write_buffer.sv
// Directed bench for burst_write_buffer with a cycle-level reference model.
module tb_burst_write_buffer;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BL = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_wr;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_din;
    logic          in_wait_n;
    logic          out_wr;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_din;
    logic [7:0]    out_burst_length;
    logic          out_wait_n;
    logic          out_burst_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    burst_write_buffer #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .BURST_LENGTH (BL)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .in_wr_i            (in_wr),
        .in_addr_i          (in_addr),
        .in_din_i           (in_din),
        .in_wait_n_o        (in_wait_n),
        .out_wr_o           (out_wr),
        .out_addr_o         (out_addr),
        .out_din_o          (out_din),
        .out_burst_length_o (out_burst_length),
        .out_wait_n_i       (out_wait_n),
        .out_burst_done_i   (out_burst_done)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference model: a line of words, how many have arrived, and how many
    // of a full line have been handed to DDR. Checked every falling edge.
    logic [DW-1:0] m_line [BL];
    logic [AW-1:0] m_base;
    int            m_fill;
    int            m_sent;
    bit            m_sending;
    bit            m_waiting;
    bit            m_ready;

    initial begin
        m_fill = 0; m_sent = 0; m_sending = 0; m_waiting = 0; m_base = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_fill = 0; m_sent = 0; m_sending = 0; m_waiting = 0; m_base = '0;
                chk("rst_in_wait_n", in_wait_n, 1);
                chk("rst_out_wr", out_wr, 0);
                chk("rst_out_addr", out_addr, 0);
            end else begin
                m_ready = !m_sending && !m_waiting;
                chk("model_in_wait_n", in_wait_n, m_ready);
                chk("model_out_wr", out_wr, m_sending);
                if (m_sending) begin
                    chk("model_out_addr", out_addr, m_base);
                    chk("model_out_din", out_din, m_line[m_sent]);
                end
                if (m_ready) begin
                    if (in_wr) begin
                        m_line[int'((in_addr >> 3) % BL)] = in_din;
                        if (m_fill == 0) m_base = in_addr & ~AW'(BL * 8 - 1);
                        m_fill++;
                        if (m_fill == BL) begin
                            m_fill = 0; m_sent = 0; m_sending = 1;
                        end
                    end
                end else if (m_sending) begin
                    if (out_wait_n) begin
                        m_sent++;
                        if (m_sent == BL) begin
                            m_sending = 0;
                            m_waiting = !out_burst_done;
                        end
                    end
                end else if (out_burst_done) begin
                    m_waiting = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_words(input logic [AW-1:0] base, input int first, input int n,
                              input logic [DW-1:0] d0);
        for (int i = first; i < first + n; i++) begin
            in_wr   = 1'b1;
            in_addr = base + AW'(8 * i);
            in_din  = d0 + DW'(i);
            tick();
        end
        in_wr = 1'b0;
    endtask

    // Drive one burst to completion and check the delivered word stream.
    task automatic run_burst(input logic [AW-1:0] base, input logic [DW-1:0] d0,
                             input bit toggle, input int late, input bit hold_wr,
                             output int cycles);
        logic [DW-1:0] q[$];
        int  k;
        int  dw;
        bit  addr_ok;
        k = 0; dw = 0; addr_ok = 1;
        chk("handoff_out_wr", out_wr, 1);
        chk("handoff_in_wait_n", in_wait_n, 0);
        while (q.size() < BL && k < 100) begin
            out_wait_n     = toggle ? ((k % 2) == 1) : 1'b1;
            in_wr          = hold_wr && (q.size() < BL - 1);
            in_addr        = base;
            in_din         = 64'hdead;
            out_burst_done = out_wr && out_wait_n && (q.size() == BL - 1) && (late == 0);
            if (out_wr && out_wait_n) begin
                q.push_back(out_din);
                if (out_addr != base) addr_ok = 0;
            end
            tick();
            k++;
        end
        cycles = k;
        out_burst_done = 1'b0; in_wr = 1'b0; out_wait_n = 1'b1;
        chk("burst_words", q.size(), BL);
        foreach (q[i]) chk("burst_din_seq", q[i], d0 + DW'(i));
        chk("burst_addr_const", addr_ok, 1);
        if (late > 0) begin
            for (int j = 1; j <= late; j++) begin
                if (!out_wr && !in_wait_n) dw++;
                out_burst_done = (j == late);
                tick();
            end
            out_burst_done = 1'b0;
            chk("done_wait_cycles", dw, late);
        end
        chk("fill_resumed_in_wait_n", in_wait_n, 1);
        chk("fill_resumed_out_wr", out_wr, 0);
    endtask

    initial begin
        int cyc;
        int cnt;
        int k;
        in_wr = 0; in_addr = '0; in_din = '0; out_wait_n = 1; out_burst_done = 0;
        rst_n = 0;
        repeat (3) tick();
        chk("rst_burst_length", out_burst_length, 16);
        chk("rst_in_wait_n_lit", in_wait_n, 1);
        chk("rst_out_wr_lit", out_wr, 0);
        rst_n = 1;
        tick();

        // Basic line at 0x100, done one cycle after the last word.
        send_words(32'h100, 0, BL, 64'd0);
        chk("t1_out_addr", out_addr, 32'h100);
        run_burst(32'h100, 64'd0, 0, 1, 0, cyc);
        chk("t1_burst_cycles", cyc, 16);

        // Output stalled every other cycle.
        send_words(32'h100, 0, BL, 64'd100);
        run_burst(32'h100, 64'd100, 1, 0, 0, cyc);
        chk("t2_burst_cycles", cyc, 32);

        // Done coincident with last word, then done five cycles late.
        send_words(32'h300, 0, BL, 64'd300);
        run_burst(32'h300, 64'd300, 0, 0, 0, cyc);
        send_words(32'h380, 0, BL, 64'd350);
        run_burst(32'h380, 64'd350, 0, 5, 0, cyc);

        // Input write held during the burst must be ignored.
        send_words(32'h400, 0, BL, 64'd400);
        run_burst(32'h400, 64'd400, 0, 0, 1, cyc);
        send_words(32'h500, 0, BL, 64'd500);
        run_burst(32'h500, 64'd500, 0, 0, 0, cyc);
        chk("t4_next_line_cycles", cyc, 16);

        // Reset while word 7 is on the output.
        send_words(32'h100, 0, BL, 64'd600);
        cnt = 0; k = 0;
        while (cnt < 7 && k < 50) begin
            out_wait_n = 1'b1;
            if (out_wr && out_wait_n) cnt++;
            tick();
            k++;
        end
        chk("t5_word7_din", out_din, 64'd607);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_wr", out_wr, 0);
        chk("t5_rst_in_wait_n", in_wait_n, 1);
        tick();
        rst_n = 1'b1;
        tick();
        send_words(32'h200, 0, BL, 64'd700);
        chk("t5_out_addr", out_addr, 32'h200);
        run_burst(32'h200, 64'd700, 0, 0, 0, cyc);

        // Spurious done after three words of a line.
        send_words(32'h600, 0, 3, 64'd800);
        out_burst_done = 1'b1;
        tick();
        out_burst_done = 1'b0;
        chk("t6_in_wait_n", in_wait_n, 1);
        chk("t6_out_wr", out_wr, 0);
        send_words(32'h600, 3, BL - 3, 64'd800);
        run_burst(32'h600, 64'd800, 0, 0, 0, cyc);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
